timer_sequencer: RTL and testbench
==================================

Name: timer_sequencer

Overview:
- Control FSM for the minute/second countdown datapath: the mod10/mod06 seconds stages and the two BCD minute down-counters.
- Turns raw board buttons into load and count-enable, and validates the BCD minute setting before loading it.
- Supervises the datapath done/error flags and selects the 7-segment display mode.
- Runs on the fast board clock and pairs with the 1 Hz enable generator's tick.

Parameters:
ALARM_SECS, 10, number of 1 Hz ticks the ALARM state lasts before auto-return to IDLE
ALM_W, 4, width of alarm tick counter (must hold ALARM_SECS)

Ports:
clk  in  1  board clock
reset  in  1  synchronous active-low reset (0 at posedge clk = reset)
tick_1hz  in  1  one-clk-wide pulse, once per second, from 1 Hz generator
btn_load  in  1  raw async button, load minute setting
btn_start  in  1  raw async button, start/resume
btn_pause  in  1  raw async button, pause
set_m1  in  4  BCD tens-of-minutes setting
set_m0  in  4  BCD units-of-minutes setting
dp_done  in  1  datapath reached 00:00
dp_err  in  1  datapath error flag
load  out  1  load strobe to minute counters
ce  out  1  count enable to seconds stage
alarm  out  1  blinking alarm LED
err_led  out  1  controller-level error indicator
disp_mode  out  3  0=idle text, 1=run, 2=paused, 3=alarm, 4=error
busy  out  1  high in LOAD, RUN, PAUSE

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; load=ce=alarm=err_led=busy=0; disp_mode=0; synchronizer flops and alarm counter cleared.
- Buttons: each passes a 2-flop synchronizer, then a rising-edge detector.
  - Pin rise → 1-cycle internal pulse, visible to the FSM on the 3rd posedge after the pin rises.
  - A held button yields exactly one pulse.
- Setting validity: valid iff set_m1<=9, set_m0<=9, and {set_m1,set_m0}!=00.
- IDLE: load pulse & valid → LOAD; load pulse & invalid → ERROR; other pulses ignored.
- LOAD: load=1 from state entry through the cycle in which tick_1hz=1 (inclusive), so the 1 Hz-clocked counters sample it. Then → PAUSE with load=0. ce=0 throughout.
- PAUSE: ce=0.
  - start pulse → RUN.
  - load pulse → revalidate, as in IDLE.
  - pause pulse ignored.
- RUN: ce=1.
  - Priority: dp_err → ERROR, else dp_done → ALARM, else pause pulse → PAUSE.
  - start and load pulses ignored.
  - ce falls in the same cycle the state leaves RUN (registered output, one cycle after the triggering input).
- ALARM: ce=0; alarm counter cleared on entry.
  - Each tick_1hz: alarm toggles and the counter increments.
  - When the counter reaches ALARM_SECS, or on any button pulse: → IDLE with alarm=0.
- ERROR: err_led=1, ce=0.
  - Load pulse & valid → LOAD with err_led=0.
  - Anything else: stay in ERROR.
- dp_err is honoured only in RUN and PAUSE; dp_done only in RUN.
- Simultaneous pulses in the same cycle: load > pause > start; lower-priority pulses are dropped, not queued.
- disp_mode is registered and tracks the state. LOAD shows 2.
- busy=1 in LOAD, RUN, PAUSE.
- Reset mid-operation (including mid-LOAD or mid-ALARM) aborts immediately to IDLE; no load or ce glitch after reset.
- Alarm counter saturates; never wraps.

Decomposition:
- Shared package: state encoding localparams (IDLE, LOAD, PAUSE, RUN, ALARM, ERROR) and DISP_* mode codes, also consumed by the display module.
- One sub-module: btn_sync_edge, the 2-flop synchronizer plus rising-edge pulse. Instantiated three times.

Test Plan:
- Reset low 2 cycles, then set 2,5 and pulse btn_load → load high until the first tick_1hz, then state PAUSE, disp_mode=2, ce=0.
- From PAUSE, pulse btn_start → ce=1 and disp_mode=1 on the 4th posedge after the pin rise; btn_pause → ce=0 and disp_mode=2.
- Set m1=4'hA (or 0,0) and pulse load in IDLE → err_led=1, disp_mode=4, load never asserted; then set 0,3 and load → LOAD, err_led=0.
- In RUN, raise dp_done → ALARM. With ALARM_SECS=10, alarm toggles on each of 10 ticks, then IDLE with alarm=0. A repeat run in which btn_start is pressed at tick 3 ends ALARM early.
- In RUN, raise dp_done and dp_err in the same cycle → ERROR. Pulse load and pause in the same cycle from PAUSE → LOAD taken, pause dropped.
- Drop reset to 0 during LOAD before the tick → next cycle load=0, state IDLE, all outputs 0.

Source files
------------

// File: rtl/timer_sequencer_pkg.sv
// Shared encodings for the countdown-timer controller and the display decoder.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package timer_sequencer_pkg;

    // Controller state encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_PAUSE = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_ALARM = 3'd4;
    localparam logic [2:0] ST_ERROR = 3'd5;

    // 7-segment display mode codes
    localparam logic [2:0] DISP_IDLE   = 3'd0;
    localparam logic [2:0] DISP_RUN    = 3'd1;
    localparam logic [2:0] DISP_PAUSED = 3'd2;
    localparam logic [2:0] DISP_ALARM  = 3'd3;
    localparam logic [2:0] DISP_ERROR  = 3'd4;

    // A minute setting is loadable only if both digits are BCD and it is not 00
    function automatic logic setting_valid(input logic [3:0] m1, input logic [3:0] m0);
        return (m1 <= 4'd9) && (m0 <= 4'd9) && ({m1, m0} != 8'h00);
    endfunction

    // Display mode shown for each state; LOAD shares the paused screen
    function automatic logic [2:0] disp_for_state(input logic [2:0] st);
        logic [2:0] d;
        case (st)
            ST_LOAD:  d = DISP_PAUSED;
            ST_PAUSE: d = DISP_PAUSED;
            ST_RUN:   d = DISP_RUN;
            ST_ALARM: d = DISP_ALARM;
            ST_ERROR: d = DISP_ERROR;
            default:  d = DISP_IDLE;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/timer_sequencer_btn_sync_edge.sv
// Raw button -> 2-flop synchronizer -> registered one-cycle rising-edge pulse.
// Latency: pulse is high in the cycle after the 3rd posedge following the pin rise.
// Backpressure: none; a held button yields exactly one pulse, presses are never queued.
module timer_sequencer_btn_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic pulse_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic pulse_q;

    // Synchronize the asynchronous pin and register its rising edge
    always_ff @(posedge clk) begin
        if (!reset) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            meta_q  <= btn_i;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            pulse_q <= sync_q & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/timer_sequencer.sv
// Control FSM for the mm:ss countdown: button handling, setting check, alarm/error supervision.
// Latency: all outputs registered; they change on the same edge as the state (one cycle after the cause).
// Backpressure: none; button pulses that are not acted on in the current state are dropped.
module timer_sequencer
    import timer_sequencer_pkg::*;
#(
    parameter int ALARM_SECS = 10,
    parameter int ALM_W      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       btn_load,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic [3:0] set_m1,
    input  logic [3:0] set_m0,
    input  logic       dp_done,
    input  logic       dp_err,
    output logic       load,
    output logic       ce,
    output logic       alarm,
    output logic       err_led,
    output logic [2:0] disp_mode,
    output logic       busy
);

    localparam logic [ALM_W-1:0] ALM_MAX = ALM_W'(ALARM_SECS);

    logic             ld_raw, st_raw, pa_raw;
    logic             ld_p, st_p, pa_p, any_p;
    logic             setting_ok;

    logic [2:0]       state_q, state_d;
    logic [ALM_W-1:0] alm_cnt_q, alm_cnt_d;
    logic             alarm_q, alarm_d;
    logic             load_q, load_d;
    logic             ce_q, ce_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic [2:0]       disp_q, disp_d;

    timer_sequencer_btn_sync_edge u_btn_load (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (btn_load),
        .pulse_o (ld_raw)
    );

    timer_sequencer_btn_sync_edge u_btn_start (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (btn_start),
        .pulse_o (st_raw)
    );

    timer_sequencer_btn_sync_edge u_btn_pause (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (btn_pause),
        .pulse_o (pa_raw)
    );

    // Same-cycle presses resolve load > pause > start; losers are discarded
    assign ld_p       = ld_raw;
    assign pa_p       = pa_raw & ~ld_raw;
    assign st_p       = st_raw & ~ld_raw & ~pa_raw;
    assign any_p      = ld_raw | st_raw | pa_raw;
    assign setting_ok = setting_valid(set_m1, set_m0);

    // State register plus registered outputs and alarm bookkeeping
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            alm_cnt_q <= '0;
            alarm_q   <= 1'b0;
            load_q    <= 1'b0;
            ce_q      <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            disp_q    <= DISP_IDLE;
        end else begin
            state_q   <= state_d;
            alm_cnt_q <= alm_cnt_d;
            alarm_q   <= alarm_d;
            load_q    <= load_d;
            ce_q      <= ce_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            disp_q    <= disp_d;
        end
    end

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ld_p) state_d = setting_ok ? ST_LOAD : ST_ERROR;
            end
            ST_LOAD: begin
                // Hold the load strobe until the 1 Hz domain has sampled it
                if (tick_1hz) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (dp_err)    state_d = ST_ERROR;
                else if (ld_p) state_d = setting_ok ? ST_LOAD : ST_ERROR;
                else if (st_p) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (dp_err)       state_d = ST_ERROR;
                else if (dp_done) state_d = ST_ALARM;
                else if (pa_p)    state_d = ST_PAUSE;
            end
            ST_ALARM: begin
                if (any_p || (alm_cnt_q == ALM_MAX)) state_d = ST_IDLE;
            end
            ST_ERROR: begin
                if (ld_p && setting_ok) state_d = ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output values for the state being entered; alarm blinks only while staying in ALARM
    always_comb begin
        load_d    = (state_d == ST_LOAD);
        ce_d      = (state_d == ST_RUN);
        err_d     = (state_d == ST_ERROR);
        busy_d    = (state_d == ST_LOAD) || (state_d == ST_RUN) || (state_d == ST_PAUSE);
        disp_d    = disp_for_state(state_d);
        alm_cnt_d = '0;
        alarm_d   = 1'b0;
        if ((state_q == ST_ALARM) && (state_d == ST_ALARM)) begin
            alm_cnt_d = alm_cnt_q;
            alarm_d   = alarm_q;
            if (tick_1hz) begin
                alarm_d = ~alarm_q;
                if (alm_cnt_q != ALM_MAX) alm_cnt_d = alm_cnt_q + 1'b1;
            end
        end
    end

    assign load      = load_q;
    assign ce        = ce_q;
    assign alarm     = alarm_q;
    assign err_led   = err_q;
    assign busy      = busy_q;
    assign disp_mode = disp_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// Self-checking bench for timer_sequencer: directed scenarios plus a randomized walk against a mode-level model.
// Latency: button effects are checked on the 4th posedge after the pin rise.
// Backpressure: n/a.
module tb_timer_sequencer;

    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_PAUSE = 2;
    localparam int M_RUN   = 3;
    localparam int M_ALARM = 4;
    localparam int M_ERROR = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       btn_load = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_pause = 1'b0;
    logic [3:0] set_m1 = 4'd0;
    logic [3:0] set_m0 = 4'd0;
    logic       dp_done = 1'b0;
    logic       dp_err = 1'b0;
    logic       load, ce, alarm, err_led, busy;
    logic [2:0] disp_mode;
    logic [7:0] obs;

    int n_checks = 0;
    int n_fails  = 0;
    int mode     = M_IDLE;
    bit load_seen = 1'b0;

    timer_sequencer #(.ALARM_SECS(10), .ALM_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .tick_1hz  (tick_1hz),
        .btn_load  (btn_load),
        .btn_start (btn_start),
        .btn_pause (btn_pause),
        .set_m1    (set_m1),
        .set_m0    (set_m0),
        .dp_done   (dp_done),
        .dp_err    (dp_err),
        .load      (load),
        .ce        (ce),
        .alarm     (alarm),
        .err_led   (err_led),
        .disp_mode (disp_mode),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    assign obs = {load, ce, alarm, err_led, busy, disp_mode};

    always @(posedge clk) if (load === 1'b1) load_seen = 1'b1;

    // Expected {load, ce, alarm, err_led, busy, disp_mode} for a controller mode
    function automatic logic [7:0] exp_vec(input int m, input logic alm);
        logic [2:0] d;
        case (m)
            M_LOAD:  d = 3'd2;
            M_PAUSE: d = 3'd2;
            M_RUN:   d = 3'd1;
            M_ALARM: d = 3'd3;
            M_ERROR: d = 3'd4;
            default: d = 3'd0;
        endcase
        return {m == M_LOAD, m == M_RUN, alm, m == M_ERROR,
                (m == M_LOAD) || (m == M_PAUSE) || (m == M_RUN), d};
    endfunction

    function automatic bit setting_ok(input int a, input int b);
        return (a < 10) && (b < 10) && ((a * 10 + b) > 0);
    endfunction

    // Mode after a button press; mask bit0 load, bit1 start, bit2 pause
    function automatic int model_next(input int m, input logic [2:0] mask, input int a, input int b);
        int btn;
        bit ok;
        ok = setting_ok(a, b);
        if (mask[0])      btn = 1;
        else if (mask[2]) btn = 3;
        else if (mask[1]) btn = 2;
        else              btn = 0;
        case (m)
            M_IDLE:  if (btn == 1) return ok ? M_LOAD : M_ERROR;
            M_PAUSE: begin
                if (btn == 1) return ok ? M_LOAD : M_ERROR;
                if (btn == 2) return M_RUN;
            end
            M_RUN:   if (btn == 3) return M_PAUSE;
            M_ALARM: if (btn != 0) return M_IDLE;
            M_ERROR: if (btn == 1 && ok) return M_LOAD;
            default: ;
        endcase
        return m;
    endfunction

    task automatic press(input logic [2:0] mask);
        @(negedge clk);
        {btn_pause, btn_start, btn_load} = mask;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic release_btns();
        @(negedge clk);
        {btn_pause, btn_start, btn_load} = 3'b000;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        @(negedge clk);
        tick_1hz = 1'b1;
        @(posedge clk);
        #1;
        tick_1hz = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        mode = M_IDLE;
    endtask

    task automatic goto_run();
        do_reset();
        set_m1 = 4'd2;
        set_m0 = 4'd5;
        press(3'b001);
        release_btns();
        do_tick();
        press(3'b010);
        release_btns();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (obs !== 8'h00) begin
            $display("FAIL reset_state: got %h expected %h", obs, 8'h00); n_fails++;
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (obs !== exp_vec(M_IDLE, 1'b0)) begin
            $display("FAIL idle_after_reset: got %h expected %h", obs, exp_vec(M_IDLE, 1'b0)); n_fails++;
        end
    endtask

    task automatic test_load_start_pause();
        set_m1 = 4'd2;
        set_m0 = 4'd5;
        press(3'b001);
        n_checks++;
        if (obs !== exp_vec(M_LOAD, 1'b0)) begin
            $display("FAIL load_entry: got %h expected %h", obs, exp_vec(M_LOAD, 1'b0)); n_fails++;
        end
        release_btns();
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (obs !== exp_vec(M_LOAD, 1'b0)) begin
            $display("FAIL load_hold_until_tick: got %h expected %h", obs, exp_vec(M_LOAD, 1'b0)); n_fails++;
        end
        @(negedge clk);
        tick_1hz = 1'b1;
        #1;
        n_checks++;
        if (load !== 1'b1) begin
            $display("FAIL load_in_tick_cycle: got %b expected 1", load); n_fails++;
        end
        @(posedge clk);
        #1;
        tick_1hz = 1'b0;
        n_checks++;
        if (obs !== exp_vec(M_PAUSE, 1'b0)) begin
            $display("FAIL pause_after_tick: got %h expected %h", obs, exp_vec(M_PAUSE, 1'b0)); n_fails++;
        end
        @(negedge clk);
        btn_start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (obs !== exp_vec(M_PAUSE, 1'b0)) begin
            $display("FAIL start_not_before_edge4: got %h expected %h", obs, exp_vec(M_PAUSE, 1'b0)); n_fails++;
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (obs !== exp_vec(M_RUN, 1'b0)) begin
            $display("FAIL start_at_edge4: got %h expected %h", obs, exp_vec(M_RUN, 1'b0)); n_fails++;
        end
        release_btns();
        press(3'b100);
        n_checks++;
        if (obs !== exp_vec(M_PAUSE, 1'b0)) begin
            $display("FAIL pause_from_run: got %h expected %h", obs, exp_vec(M_PAUSE, 1'b0)); n_fails++;
        end
        release_btns();
    endtask

    task automatic test_invalid_setting();
        do_reset();
        set_m1 = 4'hA;
        set_m0 = 4'd5;
        load_seen = 1'b0;
        press(3'b001);
        n_checks++;
        if (obs !== exp_vec(M_ERROR, 1'b0)) begin
            $display("FAIL invalid_bcd_error: got %h expected %h", obs, exp_vec(M_ERROR, 1'b0)); n_fails++;
        end
        release_btns();
        set_m1 = 4'd0;
        set_m0 = 4'd0;
        press(3'b001);
        release_btns();
        n_checks++;
        if (obs !== exp_vec(M_ERROR, 1'b0)) begin
            $display("FAIL zero_setting_stays_error: got %h expected %h", obs, exp_vec(M_ERROR, 1'b0)); n_fails++;
        end
        n_checks++;
        if (load_seen !== 1'b0) begin
            $display("FAIL load_never_on_invalid: got %b expected 0", load_seen); n_fails++;
        end
        set_m0 = 4'd3;
        press(3'b001);
        n_checks++;
        if (obs !== exp_vec(M_LOAD, 1'b0)) begin
            $display("FAIL error_to_load: got %h expected %h", obs, exp_vec(M_LOAD, 1'b0)); n_fails++;
        end
        release_btns();
        do_tick();
        n_checks++;
        if (obs !== exp_vec(M_PAUSE, 1'b0)) begin
            $display("FAIL error_load_to_pause: got %h expected %h", obs, exp_vec(M_PAUSE, 1'b0)); n_fails++;
        end
    endtask

    task automatic test_alarm();
        goto_run();
        @(negedge clk);
        dp_done = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (obs !== exp_vec(M_ALARM, 1'b0)) begin
            $display("FAIL done_to_alarm: got %h expected %h", obs, exp_vec(M_ALARM, 1'b0)); n_fails++;
        end
        @(negedge clk);
        dp_done = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            repeat ($urandom_range(1, 4)) @(posedge clk);
            do_tick();
            if (k < 10) begin
                n_checks++;
                if (obs !== exp_vec(M_ALARM, 1'(k % 2))) begin
                    $display("FAIL alarm_tick_%0d: got %h expected %h", k, obs, exp_vec(M_ALARM, 1'(k % 2))); n_fails++;
                end
            end else begin
                repeat (2) @(posedge clk);
                #1;
                n_checks++;
                if (obs !== exp_vec(M_IDLE, 1'b0)) begin
                    $display("FAIL alarm_timeout_idle: got %h expected %h", obs, exp_vec(M_IDLE, 1'b0)); n_fails++;
                end
            end
        end
        goto_run();
        @(negedge clk);
        dp_done = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dp_done = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            repeat (2) @(posedge clk);
            do_tick();
        end
        n_checks++;
        if (obs !== exp_vec(M_ALARM, 1'b1)) begin
            $display("FAIL alarm_after_3_ticks: got %h expected %h", obs, exp_vec(M_ALARM, 1'b1)); n_fails++;
        end
        press(3'b010);
        n_checks++;
        if (obs !== exp_vec(M_IDLE, 1'b0)) begin
            $display("FAIL alarm_button_abort: got %h expected %h", obs, exp_vec(M_IDLE, 1'b0)); n_fails++;
        end
        release_btns();
    endtask

    task automatic test_priority();
        goto_run();
        @(negedge clk);
        dp_done = 1'b1;
        dp_err  = 1'b1;
        @(posedge clk);
        #1;
        dp_done = 1'b0;
        dp_err  = 1'b0;
        n_checks++;
        if (obs !== exp_vec(M_ERROR, 1'b0)) begin
            $display("FAIL err_beats_done: got %h expected %h", obs, exp_vec(M_ERROR, 1'b0)); n_fails++;
        end
        set_m1 = 4'd1;
        set_m0 = 4'd2;
        press(3'b001);
        release_btns();
        do_tick();
        set_m1 = 4'd4;
        set_m0 = 4'd0;
        press(3'b101);
        n_checks++;
        if (obs !== exp_vec(M_LOAD, 1'b0)) begin
            $display("FAIL load_beats_pause: got %h expected %h", obs, exp_vec(M_LOAD, 1'b0)); n_fails++;
        end
        release_btns();
        do_tick();
        @(negedge clk);
        dp_done = 1'b1;
        @(posedge clk);
        #1;
        dp_done = 1'b0;
        n_checks++;
        if (obs !== exp_vec(M_PAUSE, 1'b0)) begin
            $display("FAIL done_ignored_in_pause: got %h expected %h", obs, exp_vec(M_PAUSE, 1'b0)); n_fails++;
        end
        @(negedge clk);
        dp_err = 1'b1;
        @(posedge clk);
        #1;
        dp_err = 1'b0;
        n_checks++;
        if (obs !== exp_vec(M_ERROR, 1'b0)) begin
            $display("FAIL err_in_pause: got %h expected %h", obs, exp_vec(M_ERROR, 1'b0)); n_fails++;
        end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        set_m1 = 4'd2;
        set_m0 = 4'd5;
        press(3'b001);
        release_btns();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (obs !== 8'h00) begin
            $display("FAIL reset_mid_load: got %h expected %h", obs, 8'h00); n_fails++;
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (obs !== 8'h00) begin
            $display("FAIL no_glitch_after_reset: got %h expected %h", obs, 8'h00); n_fails++;
        end
        mode = M_IDLE;
    endtask

    task automatic test_random();
        int a, b, r;
        logic [2:0] mask;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7) begin
                mask = 3'($urandom_range(1, 7));
                a = $urandom_range(0, 11);
                b = $urandom_range(0, 11);
                set_m1 = 4'(a);
                set_m0 = 4'(b);
                press(mask);
                mode = model_next(mode, mask, a, b);
                n_checks++;
                if (obs !== exp_vec(mode, 1'b0)) begin
                    $display("FAIL rand_press_%0d mask %b: got %h expected %h", i, mask, obs, exp_vec(mode, 1'b0)); n_fails++;
                end
                release_btns();
            end else begin
                @(negedge clk);
                dp_done = (r != 8);
                dp_err  = (r != 7);
                @(posedge clk);
                #1;
                if ((mode == M_RUN || mode == M_PAUSE) && dp_err) mode = M_ERROR;
                else if (mode == M_RUN && dp_done) mode = M_ALARM;
                dp_done = 1'b0;
                dp_err  = 1'b0;
                n_checks++;
                if (obs !== exp_vec(mode, 1'b0)) begin
                    $display("FAIL rand_dp_%0d: got %h expected %h", i, obs, exp_vec(mode, 1'b0)); n_fails++;
                end
            end
            if (mode == M_LOAD) begin
                do_tick();
                mode = M_PAUSE;
                n_checks++;
                if (obs !== exp_vec(mode, 1'b0)) begin
                    $display("FAIL rand_tick_%0d: got %h expected %h", i, obs, exp_vec(mode, 1'b0)); n_fails++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_start_pause();
        test_invalid_setting();
        test_alarm();
        test_priority();
        test_reset_mid_load();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
